// File: rtl/pc_seq_pkg.sv
// Shared definitions for the KGP-miniRISC program-counter stage:
// FSM state encoding and default address-path constants.
package pc_seq_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int DEF_PC_W     = 32;
  localparam int DEF_PC_STEP  = 4;
  localparam int DEF_RESET_PC = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/redirect bundle between decode/branch_control and the PC stage.
// master drives the decoded controls; slave (the sequencer) returns pc and status.
interface pc_sequencer_if #(
  parameter int PC_W = 32
) ();

  logic            stall;
  logic            branch_valid;
  logic [PC_W-1:0] branch_target;
  logic            is_call;
  logic            is_ret;
  logic            is_halt;
  logic            resume;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic            halted;
  logic            ras_err;

  modport master (
    output stall, branch_valid, branch_target, is_call, is_ret, is_halt, resume,
    input  pc, flush, halted, ras_err
  );

  modport slave (
    input  stall, branch_valid, branch_target, is_call, is_ret, is_halt, resume,
    output pc, flush, halted, ras_err
  );

endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry, so the newest DEPTH return addresses always survive.
module ras_stack #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_push_data,
  output logic [W-1:0] o_pop_data,
  output logic         o_empty,
  output logic         o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // r_top indexes the next free slot; DEPTH is a power of two so it wraps for free
  logic [PTR_W-1:0] r_top;
  logic [PTR_W:0]   r_count;
  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] w_top_m1;

  assign w_top_m1   = r_top - PTR_W'(1);
  assign o_pop_data = r_mem[w_top_m1];
  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (i_push) begin
      r_top <= r_top + PTR_W'(1);
      if (!o_full) r_count <= r_count + (PTR_W+1)'(1);
    end else if (i_pop && !o_empty) begin
      r_top   <= w_top_m1;
      r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // Entry storage carries no reset; r_count alone defines which slots are valid
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_top] <= i_push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and next-PC selection: sequential, branch, call, return,
// halt. Redirects raise a one-cycle registered flush alongside the new pc.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = DEF_PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] PC_STEP   = PC_W'(DEF_PC_STEP),
  parameter int              RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  pc_sequencer_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_inc;
  logic            r_flush;
  logic            w_flush_nxt;
  logic            r_err;
  logic            w_err_set;
  logic            w_push;
  logic            w_pop;
  logic [PC_W-1:0] w_pop_data;
  logic            w_empty;
  logic            w_full;

  assign w_pc_inc = r_pc + PC_STEP;

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_pc_inc),
    .o_pop_data  (w_pop_data),
    .o_empty     (w_empty),
    .o_full      (w_full)
  );

  // Priority chain: stall > halt > ret > call > branch > sequential
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_flush_nxt = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (bus.resume) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (bus.stall) begin
          w_pc_nxt = r_pc;
        end else if (bus.is_halt) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_HALT;
        end else if (bus.is_ret) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_pc_nxt    = w_pop_data;
            w_flush_nxt = 1'b1;
          end else begin
            w_pc_nxt  = w_pc_inc;
            w_err_set = 1'b1;
          end
        end else if (bus.is_call) begin
          w_push      = 1'b1;
          w_pc_nxt    = bus.branch_target;
          w_flush_nxt = 1'b1;
          w_err_set   = w_full;
        end else if (bus.branch_valid) begin
          w_pc_nxt    = bus.branch_target;
          w_flush_nxt = 1'b1;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_flush <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_flush <= w_flush_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  assign bus.pc      = r_pc;
  assign bus.flush   = r_flush;
  assign bus.halted  = (r_state == ST_HALT);
  assign bus.ras_err = r_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model with a queue-based
// return stack predicts {pc, flush, halted, ras_err} after every clock.
module tb_pc_sequencer;

  localparam int PC_W = 32;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            halted;
    logic            err;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pc_sequencer_if #(.PC_W(PC_W)) bus ();

  pc_sequencer #(
    .PC_W      (PC_W),
    .RESET_PC  (32'h0),
    .PC_STEP   (32'd4),
    .RAS_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  obs_t sb_exp[$];
  obs_t sb_obs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic [PC_W-1:0] m_pc;
  logic            m_flush, m_halt, m_err;
  logic [PC_W-1:0] m_ras[$];

  task automatic model_reset();
    m_pc = '0; m_flush = 1'b0; m_halt = 1'b0; m_err = 1'b0;
    m_ras.delete();
  endtask

  task automatic clear_inputs();
    bus.stall = 0; bus.branch_valid = 0; bus.branch_target = '0;
    bus.is_call = 0; bus.is_ret = 0; bus.is_halt = 0; bus.resume = 0;
  endtask

  // Drive one cycle of inputs, predict the outcome, capture what the DUT shows.
  task automatic apply(input logic st, input logic bv, input logic [PC_W-1:0] tgt,
                       input logic call, input logic ret, input logic hlt, input logic res);
    bus.stall = st; bus.branch_valid = bv; bus.branch_target = tgt;
    bus.is_call = call; bus.is_ret = ret; bus.is_halt = hlt; bus.resume = res;
    if (m_halt) begin
      m_flush = 1'b0;
      if (res) m_halt = 1'b0;
    end else if (st) begin
      m_flush = 1'b0;
    end else if (hlt) begin
      m_pc = m_pc + 32'd4; m_halt = 1'b1; m_flush = 1'b0;
    end else if (ret) begin
      if (m_ras.size() > 0) begin
        m_pc = m_ras.pop_back(); m_flush = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4; m_err = 1'b1; m_flush = 1'b0;
      end
    end else if (call) begin
      m_ras.push_back(m_pc + 32'd4);
      if (m_ras.size() > 4) begin
        m_ras.delete(0);
        m_err = 1'b1;
      end
      m_pc = tgt; m_flush = 1'b1;
    end else if (bv) begin
      m_pc = tgt; m_flush = 1'b1;
    end else begin
      m_pc = m_pc + 32'd4; m_flush = 1'b0;
    end
    sb_exp.push_back(obs_t'({m_pc, m_flush, m_halt, m_err}));
    @(posedge clk);
    #1;
    sb_obs.push_back(obs_t'({bus.pc, bus.flush, bus.halted, bus.ras_err}));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic jump(input logic [PC_W-1:0] tgt);
    apply(0, 1, tgt, 0, 0, 0, 0);
  endtask

  // Async reset: outputs must clear without waiting for a clock edge.
  task automatic async_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    sb_exp.push_back(obs_t'({32'h0, 1'b0, 1'b0, 1'b0}));
    sb_obs.push_back(obs_t'({bus.pc, bus.flush, bus.halted, bus.ras_err}));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e, o;
    async_reset();
    idle(3);
    async_reset();
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL reset: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, o;
    idle(2);
    jump(32'h40);
    idle(1);
    jump(32'hFFFF_FFFC);
    idle(2);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL branch: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_call_ret();
    obs_t e, o;
    async_reset();
    jump(32'h10);
    apply(0, 0, 32'h100, 1, 0, 0, 0);
    idle(1);
    apply(0, 0, '0, 0, 1, 0, 0);
    idle(1);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL call_ret: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_ras_overflow();
    obs_t e, o;
    async_reset();
    jump(32'h1000);
    for (int i = 0; i < 5; i++) apply(0, 0, 32'((i + 2) << 12), 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 0, '0, 0, 1, 0, 0);
    idle(1);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL ras_overflow: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_halt();
    obs_t e, o;
    async_reset();
    jump(32'h20);
    apply(0, 0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) apply(i[0], 1, 32'h80, i[1], i[2], 0, 0);
    apply(0, 0, '0, 0, 0, 0, 1);
    idle(1);
    apply(0, 0, '0, 0, 0, 1, 0);
    async_reset();
    idle(1);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL halt: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_stall_priority();
    obs_t e, o;
    async_reset();
    jump(32'h30);
    apply(1, 1, 32'h90, 0, 0, 0, 0);
    apply(0, 1, 32'h90, 0, 0, 0, 0);
    jump(32'h4C);
    apply(0, 0, 32'hA0, 1, 0, 0, 0);
    apply(0, 1, 32'hC0, 1, 1, 0, 0);
    apply(0, 0, '0, 0, 1, 0, 0);
    apply(0, 1, 32'hE0, 0, 0, 1, 0);
    apply(0, 0, '0, 0, 0, 0, 1);
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL stall_priority: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    async_reset();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom % 8) == 0, ($urandom % 3) == 0, $urandom & 32'hFFFF_FFFC,
            ($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 25) == 0,
            ($urandom % 3) == 0);
    end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front(); o = sb_obs.pop_front(); n_vec++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL back_to_back: got pc=%h flush=%b halted=%b err=%b, want pc=%h flush=%b halted=%b err=%b",
                 o.pc, o.flush, o.halted, o.err, e.pc, e.flush, e.halted, e.err);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_branch();
    test_call_ret();
    test_ras_overflow();
    test_halt();
    test_stall_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter and next-PC stage of KGP-miniRISC. It sits directly downstream of branch_control and consumes its branch_valid decision.
- Holds the architectural PC and selects the next fetch address from: sequential, taken branch, call, return, or halt.
- Contains a small return-address stack (RAS) for call/ret, and a RUN/HALT state machine.
- Drives the instruction-memory address and a one-cycle flush to the fetch/decode pipeline register.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 4, sequential increment (byte-addressed 32-bit instructions).
- RAS_DEPTH, 4, number of return-address stack entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold all state this cycle.
- branch_valid  in  1  conditional or unconditional branch taken (from branch_control).
- branch_target  in  PC_W  target for branch and call.
- is_call  in  1  decoded call instruction at current pc.
- is_ret  in  1  decoded return instruction at current pc.
- is_halt  in  1  decoded halt instruction at current pc.
- resume  in  1  external restart request while halted.
- pc  out  PC_W  current fetch address.
- flush  out  1  registered pulse; high in the cycle a redirected pc first appears.
- halted  out  1  high while in the HALT state.
- ras_err  out  1  sticky flag; set on RAS overflow or underflow.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, flush=0, halted=0, ras_err=0.
  - State=RUN; RAS empty (count=0, top pointer=0).
  - Takes effect immediately, including mid-halt or mid-redirect.
- State machine:
  - RUN: one next-PC decision per cycle, per the priority list below.
  - HALT: pc, RAS and ras_err frozen; flush=0; stall and the is_*/branch_valid inputs are ignored. resume=1 returns to RUN on the next edge; pc is unchanged on that edge.
- Priority in RUN (highest first):
  1. stall=1: hold everything; flush<=0; no push/pop.
  2. is_halt: pc<=pc+PC_STEP, state<=HALT, flush<=0.
  3. is_ret:
     - Non-empty RAS: pop; pc<=popped value; flush<=1.
     - Empty RAS: pc<=pc+PC_STEP; ras_err<=1; flush<=0.
  4. is_call:
     - Push pc+PC_STEP; pc<=branch_target; flush<=1.
     - Full RAS: push wraps and overwrites the oldest entry; count stays RAS_DEPTH; ras_err<=1.
  5. branch_valid: pc<=branch_target; flush<=1.
  6. Otherwise: pc<=pc+PC_STEP; flush<=0.
- Simultaneous inputs:
  - is_call and is_ret together: ret wins; no push.
  - branch_valid together with any is_* input: branch_valid is ignored.
- Latency: a decision is made in cycle N. The new pc and flush appear in cycle N+1.
- flush is never high for two consecutive cycles unless redirects occur back-to-back.
- Arithmetic: pc+PC_STEP wraps modulo 2^PC_W with no error. branch_target is used unmodified, with no alignment check.
- RAS: circular buffer of RAS_DEPTH x PC_W with a top pointer and a count from 0 to RAS_DEPTH. Pop decrements both. Overflow wrap keeps the most recent RAS_DEPTH return addresses.
- ras_err is cleared only by reset.

Decomposition:
- Shared package pc_seq_pkg: state encoding (ST_RUN=1'b0, ST_HALT=1'b1), default PC_W/PC_STEP/RESET_PC constants.
- One sub-module: ras_stack. Inputs push, pop, push_data; outputs pop_data, empty, full. Contains its own pointer and count, and resets on rst_n.
- Top level holds the FSM, pc register, next-pc mux and flush register.

Test Plan:
- Reset then 3 free-running cycles -> pc=0,4,8,12; flush=0; halted=0. Assert rst_n=0 at pc=12 -> pc=0 immediately.
- At pc=8, branch_valid=1, branch_target=0x40 -> next cycle pc=0x40, flush=1; following cycle pc=0x44, flush=0.
- At pc=0x10, is_call, target=0x100; at pc=0x104, is_ret -> pc goes 0x100, 0x104, then 0x14, with flush=1 on both redirects; ras_err=0.
- Five nested calls with RAS_DEPTH=4, then five rets -> ras_err=1 after the 5th call. The first four rets return to the four newest return addresses. The 5th ret (RAS now empty) gives pc+4 with no flush.
- At pc=0x20, is_halt with stall=0 -> pc=0x24, halted=1. Ten cycles with branch_valid=1 -> pc stays 0x24. resume=1 -> halted=0, then pc=0x28 next cycle.
- At pc=0x30, stall=1 with branch_valid=1 -> pc stays 0x30, flush=0. Same cycle repeated with stall=0 -> redirect taken. Also is_call+is_ret together with RAS holding 0x50 -> pc=0x50, RAS count decremented by exactly one.
